sudoku_input_ctrl: RTL and testbench

Front-end controller that converts raw board pushbuttons and switches into the cursor and value-entry strobes consumed by the Sudoku game-compare block. It drives `locationX`/`locationY`, the one-hot write strobes `zero`/`one`/`two`/`three`, and `newGame`. It provides debounce, edge detection, wrap-around cursor movement with hold-to-repeat, and suppression of writes to locked given cells. It sits between the board I/O in the top-level and the game-compare block.

---
 rtl/sudoku_pkg.sv | 40 ++++
 rtl/sudoku_input_ctrl_key_debounce.sv | 49 ++++
 rtl/sudoku_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_sudoku_input_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared types, key indices, value codes and repeat-FSM states for the Sudoku input front end.
`default_nettype none

package sudoku_pkg;

  typedef logic [1:0] coord_t;

  localparam int GRID_N = 4;

  localparam logic [1:0] VAL_ZERO  = 2'd0;
  localparam logic [1:0] VAL_ONE   = 2'd1;
  localparam logic [1:0] VAL_TWO   = 2'd2;
  localparam logic [1:0] VAL_THREE = 2'd3;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_ENTER = 4;
  localparam int KEY_NEW   = 5;
  localparam int NKEY      = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Opposing requests cancel; a single request steps one cell with wrap-around.
  function automatic coord_t wrap_step(coord_t c, logic inc, logic dec);
    int v;
    v = int'(c);
    if (inc && !dec)      v = (v + 1) % GRID_N;
    else if (dec && !inc) v = (v + GRID_N - 1) % GRID_N;
    return coord_t'(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sudoku_input_ctrl_key_debounce.sv
// key_debounce: 2-FF synchronizer plus stable-level counter; emits one-cycle press and release events.
`default_nettype none

module key_debounce
  import sudoku_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], key_raw};
      stable_q <= stable;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt >= CNT_MAX) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = stable & ~stable_q;
  assign fall  = ~stable & stable_q;

endmodule

`default_nettype wire

// File: rtl/sudoku_input_ctrl.sv
// sudoku_input_ctrl: debounced keys -> wrapping cursor with hold-to-repeat, value strobes and new-game pulse.
`default_nettype none

module sudoku_input_ctrl
  import sudoku_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyUp,
  input  logic       keyDown,
  input  logic       keyLeft,
  input  logic       keyRight,
  input  logic       keyEnter,
  input  logic       keyNew,
  input  logic [1:0] valSel,
  input  logic       lockGivens,
  output logic [1:0] locationX,
  output logic [1:0] locationY,
  output logic       zero,
  output logic       one,
  output logic       two,
  output logic       three,
  output logic       newGame,
  output logic       writeBlocked
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [NKEY-1:0] raw, press, fall;
  rep_state_t      state, state_nxt;
  logic [2:0]      track, track_nxt;
  logic [RW-1:0]   rcnt, rcnt_nxt;
  logic            tick;
  logic [3:0]      dir_ev;
  coord_t          x_nxt, y_nxt;
  logic [3:0]      strobe_nxt;
  logic            new_nxt, blocked_nxt;

  assign raw = {keyNew, keyEnter, keyRight, keyLeft, keyDown, keyUp};

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .key_raw (raw[i]),
      .press   (press[i]),
      .fall    (fall[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      track <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      track <= track_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // A fresh direction press always wins over releases and pending ticks of the old key.
  always_comb begin
    state_nxt = state;
    track_nxt = track;
    rcnt_nxt  = rcnt;
    tick      = 1'b0;
    if (press[KEY_NEW]) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
    end else if (|press[3:0]) begin
      state_nxt = DELAY;
      rcnt_nxt  = RW'(1);
      for (int i = 0; i < 4; i++) begin
        if (press[i]) track_nxt = 3'(i);
      end
    end else if (state != IDLE && fall[track]) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
    end else if (state == DELAY) begin
      if (rcnt >= RW'(REPEAT_DELAY)) begin
        tick      = 1'b1;
        state_nxt = REPEAT;
        rcnt_nxt  = RW'(1);
      end else begin
        rcnt_nxt = rcnt + RW'(1);
      end
    end else if (state == REPEAT) begin
      if (rcnt >= RW'(REPEAT_PERIOD)) begin
        tick     = 1'b1;
        rcnt_nxt = RW'(1);
      end else begin
        rcnt_nxt = rcnt + RW'(1);
      end
    end
  end

  always_comb begin
    dir_ev      = press[3:0] | (tick ? (4'b0001 << track) : 4'b0000);
    x_nxt       = locationX;
    y_nxt       = locationY;
    strobe_nxt  = 4'b0000;
    new_nxt     = 1'b0;
    blocked_nxt = 1'b0;
    if (press[KEY_NEW]) begin
      new_nxt = 1'b1;
      x_nxt   = '0;
      y_nxt   = '0;
    end else if (press[KEY_ENTER]) begin
      if (lockGivens && (locationX == locationY)) begin
        blocked_nxt = 1'b1;
      end else begin
        case (valSel)
          VAL_ZERO:  strobe_nxt = 4'b0001;
          VAL_ONE:   strobe_nxt = 4'b0010;
          VAL_TWO:   strobe_nxt = 4'b0100;
          VAL_THREE: strobe_nxt = 4'b1000;
        endcase
      end
    end else begin
      y_nxt = wrap_step(locationY, dir_ev[KEY_DOWN], dir_ev[KEY_UP]);
      x_nxt = wrap_step(locationX, dir_ev[KEY_RIGHT], dir_ev[KEY_LEFT]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      locationX    <= '0;
      locationY    <= '0;
      {three, two, one, zero} <= 4'b0000;
      newGame      <= 1'b0;
      writeBlocked <= 1'b0;
    end else begin
      locationX    <= x_nxt;
      locationY    <= y_nxt;
      {three, two, one, zero} <= strobe_nxt;
      newGame      <= new_nxt;
      writeBlocked <= blocked_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sudoku_input_ctrl.sv
// tb_sudoku_input_ctrl: scenario tasks plus randomized key taps checked against a cursor/pulse-count model.
`default_nettype none
`timescale 1ns/1ps

module tb_sudoku_input_ctrl;

  localparam int D   = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = D + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] keys = '0;
  logic [1:0] valSel = 2'd0;
  logic       lockGivens = 1'b0;
  logic [1:0] locationX, locationY;
  logic       zero, one, two, three, newGame, writeBlocked;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pulses[6] = '{default: 0};
  int exp_p[6]  = '{default: 0};
  int multi_strobe = 0;
  int strobe_x = -1, strobe_y = -1;
  int mx = 0, my = 0;

  sudoku_input_ctrl #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset),
    .keyUp(keys[0]), .keyDown(keys[1]), .keyLeft(keys[2]), .keyRight(keys[3]),
    .keyEnter(keys[4]), .keyNew(keys[5]),
    .valSel(valSel), .lockGivens(lockGivens),
    .locationX(locationX), .locationY(locationY),
    .zero(zero), .one(one), .two(two), .three(three),
    .newGame(newGame), .writeBlocked(writeBlocked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (zero === 1'b1)         pulses[0]++;
    if (one === 1'b1)          pulses[1]++;
    if (two === 1'b1)          pulses[2]++;
    if (three === 1'b1)        pulses[3]++;
    if (newGame === 1'b1)      pulses[4]++;
    if (writeBlocked === 1'b1) pulses[5]++;
    if ((int'(zero === 1'b1) + int'(one === 1'b1) + int'(two === 1'b1) + int'(three === 1'b1)) > 1)
      multi_strobe++;
    if ((zero | one | two | three) === 1'b1) begin
      strobe_x = int'(locationX);
      strobe_y = int'(locationY);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Game rules: new > enter > moves; opposing directions cancel; coordinates wrap mod 4.
  task automatic model_apply(input logic [5:0] m);
    if (m[5]) begin
      mx = 0; my = 0; exp_p[4]++;
    end else if (m[4]) begin
      if (lockGivens && mx == my) exp_p[5]++;
      else exp_p[int'(valSel)]++;
    end else begin
      my = (my + int'(m[1]) - int'(m[0]) + 4) % 4;
      mx = (mx + int'(m[3]) - int'(m[2]) + 4) % 4;
    end
  endtask

  task automatic tap(input logic [5:0] m);
    keys = m;
    cyc(LAT + 1);
    keys = '0;
    cyc(LAT + 5);
    model_apply(m);
  endtask

  task automatic test_reset();
    keys = '1;
    reset = 1'b0;
    cyc(3);
    total_cnt++;
    if ({locationX, locationY, zero, one, two, three, newGame, writeBlocked} !== 12'd0)
      $display("FAIL reset_outputs: got %h expected 000",
               {locationX, locationY, zero, one, two, three, newGame, writeBlocked});
    else pass_cnt++;
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      total_cnt++;
      if (newGame !== (i == LAT + 1))
        $display("FAIL reset_release_newgame cycle %0d: got %b expected %b", i, newGame, (i == LAT + 1));
      else pass_cnt++;
    end
    model_apply(6'b111111);
    keys = '0;
    cyc(LAT + 5);
    for (int j = 0; j < 6; j++) begin
      total_cnt++;
      if (pulses[j] !== exp_p[j])
        $display("FAIL reset_held_keys pulse[%0d]: got %0d expected %0d", j, pulses[j], exp_p[j]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({locationX, locationY} !== 4'd0)
      $display("FAIL reset_location: got %h expected 0", {locationX, locationY});
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin
      keys[3] = ~keys[3];
      cyc(2);
    end
    keys[3] = 1'b0;
    cyc(10);
    total_cnt++;
    if (locationX !== 2'd0) $display("FAIL bounce_ignored: got X=%0d expected 0", locationX);
    else pass_cnt++;
    keys[3] = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      cyc(1);
      total_cnt++;
      if (locationX !== ((i == LAT + 1) ? 2'd1 : 2'd0))
        $display("FAIL bounce_hold_latency cycle %0d: got X=%0d", i, locationX);
      else pass_cnt++;
    end
    keys = '0;
    cyc(LAT + 5);
    mx = 1;
    total_cnt++;
    if (locationX !== 2'd1) $display("FAIL bounce_single_move: got X=%0d expected 1", locationX);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [5:0] seq[4]  = '{6'b100000, 6'b000100, 6'b000001, 6'b001000};
    int         want_x[4] = '{0, 3, 3, 0};
    int         want_y[4] = '{0, 0, 3, 3};
    for (int i = 0; i < 4; i++) begin
      tap(seq[i]);
      total_cnt++;
      if (int'(locationX) !== want_x[i] || int'(locationY) !== want_y[i])
        $display("FAIL wrap step %0d: got (%0d,%0d) expected (%0d,%0d)",
                 i, locationX, locationY, want_x[i], want_y[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_enter();
    lockGivens = 1'b0;
    tap(6'b100000);
    tap(6'b001000);
    tap(6'b000010);
    tap(6'b000010);
    valSel = 2'd2;
    tap(6'b010000);
    total_cnt++;
    if (pulses[2] !== exp_p[2] || pulses[0] !== exp_p[0] || pulses[1] !== exp_p[1] || pulses[3] !== exp_p[3])
      $display("FAIL enter_two: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", pulses[0], pulses[1],
               pulses[2], pulses[3], exp_p[0], exp_p[1], exp_p[2], exp_p[3]);
    else pass_cnt++;
    total_cnt++;
    if (strobe_x !== 1 || strobe_y !== 2)
      $display("FAIL enter_location: got (%0d,%0d) expected (1,2)", strobe_x, strobe_y);
    else pass_cnt++;
    tap(6'b001000);
    lockGivens = 1'b1;
    tap(6'b010000);
    total_cnt++;
    if (pulses[5] !== exp_p[5] || pulses[2] !== exp_p[2])
      $display("FAIL enter_locked: got blocked=%0d two=%0d expected %0d/%0d",
               pulses[5], pulses[2], exp_p[5], exp_p[2]);
    else pass_cnt++;
    lockGivens = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [5:0] combos[4] = '{6'b000011, 6'b001100, 6'b001001, 6'b000110};
    for (int i = 0; i < 4; i++) begin
      tap(combos[i]);
      total_cnt++;
      if (int'(locationX) !== mx || int'(locationY) !== my)
        $display("FAIL simultaneous %0d: got (%0d,%0d) expected (%0d,%0d)", i, locationX, locationY, mx, my);
      else pass_cnt++;
    end
  endtask

  task automatic test_repeat();
    tap(6'b100000);
    keys[1] = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      int o;
      cyc(1);
      if (i == 30) keys[1] = 1'b0;
      o = i - (LAT + 1);
      if (o >= 0 && o < 30 && (o == 0 || (o >= RD && (o - RD) % RP == 0))) my = (my + 1) % 4;
      total_cnt++;
      if (int'(locationY) !== my)
        $display("FAIL repeat cycle %0d: got Y=%0d expected %0d", i, locationY, my);
      else pass_cnt++;
    end
    cyc(10);
    total_cnt++;
    if (locationY !== 2'd0) $display("FAIL repeat_final: got Y=%0d expected 0", locationY);
    else pass_cnt++;
  endtask

  task automatic test_newgame_repeat();
    tap(6'b100000);
    keys[3] = 1'b1;
    cyc(20);
    keys[5] = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      cyc(1);
      if (j == LAT + 1) keys[5] = 1'b0;
      total_cnt++;
      if (newGame !== (j == LAT + 1))
        $display("FAIL newgame_pulse cycle %0d: got %b expected %b", j, newGame, (j == LAT + 1));
      else pass_cnt++;
      if (j >= LAT + 1) begin
        total_cnt++;
        if ({locationX, locationY} !== 4'd0)
          $display("FAIL newgame_no_resume cycle %0d: got (%0d,%0d) expected (0,0)", j, locationX, locationY);
        else pass_cnt++;
      end
    end
    keys = '0;
    cyc(LAT + 5);
    mx = 0; my = 0;
    exp_p[4]++;
    total_cnt++;
    if (pulses[4] !== exp_p[4]) $display("FAIL newgame_count: got %0d expected %0d", pulses[4], exp_p[4]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [5:0] m;
      if ($urandom_range(0, 7) == 0) m = 6'b100000;
      else m = 6'($urandom_range(1, 31));
      valSel     = 2'($urandom_range(0, 3));
      lockGivens = 1'($urandom_range(0, 1));
      tap(m);
      total_cnt++;
      if (int'(locationX) !== mx || int'(locationY) !== my)
        $display("FAIL random %0d mask %b: got (%0d,%0d) expected (%0d,%0d)", n, m, locationX, locationY, mx, my);
      else pass_cnt++;
      for (int j = 0; j < 6; j++) begin
        total_cnt++;
        if (pulses[j] !== exp_p[j])
          $display("FAIL random %0d pulse[%0d]: got %0d expected %0d", n, j, pulses[j], exp_p[j]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (multi_strobe !== 0) $display("FAIL one_hot_strobes: got %0d overlapping cycles expected 0", multi_strobe);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_wrap();
    test_enter();
    test_simultaneous();
    test_repeat();
    test_newgame_repeat();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
